// File: rtl/ser_word_rx.sv
// ser_word_rx: serial-to-parallel word receiver.
// Collects WIDTH strobed serial bits into a word, LSB-first or MSB-first as
// chosen on the start-of-frame bit, and presents each completed word on a
// valid/ready port with a single holding register and a sticky overrun flag.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   clear      - asynchronous active-high reset
//   sin        - serial data bit, sampled when sin_valid=1
//   sin_valid  - bit strobe, one bit consumed per edge where it is high
//   sof        - start of frame, qualified by sin_valid
//   dir        - bit order latched on sof: 0 LSB first, 1 MSB first
//   Out        - received word, meaningful while out_valid=1
//   out_valid  - a word is held on Out
//   out_ready  - consumer accepts Out on an edge with out_valid=1
//   busy       - a frame is partially received
//   overrun    - sticky: a completed word was dropped
module ser_word_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  input  logic             dir,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state;
  logic [WIDTH-1:0] sr;
  logic [CntW-1:0]  cnt;
  logic             dir_q;

  logic             start;
  logic             shift_dir;
  logic             complete;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    start     = sin_valid && sof;
    // A start bit is shifted with the order being latched on that same edge.
    shift_dir = start ? dir : dir_q;
    sr_next   = shift_dir ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
    // A sof bit always restarts, so it can never complete a word.
    complete  = sin_valid && !sof && (state == StShift) && (cnt == CntLast);
  end

  assign busy = (state == StShift);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= StIdle;
      sr        <= '0;
      cnt       <= '0;
      dir_q     <= 1'b0;
      Out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sin_valid) begin
        if (sof) begin
          // Restart discards any partial word silently.
          dir_q <= dir;
          sr    <= sr_next;
          cnt   <= CntW'(1);
          state <= StShift;
        end else if (state == StShift) begin
          sr <= sr_next;
          if (complete) begin
            cnt   <= '0;
            state <= StIdle;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
      end

      if (complete) begin
        if (!out_valid || out_ready) begin
          Out       <= sr_next;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ser_word_rx.sv
// Directed bench for ser_word_rx (WIDTH=4) with an expected-word queue.
module tb_ser_word_rx;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             clear;
  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic             dir;
  logic [WIDTH-1:0] Out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] tmp;

  ser_word_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .clear     (clear),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sof       (sof),
    .dir       (dir),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the rising edge.
  task automatic bit_cycle(input logic b, input logic s, input logic v, input logic d);
    sin       = b;
    sof       = s;
    sin_valid = v;
    dir       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bit_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic d, input logic rdy_last);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1 && rdy_last) out_ready = 1'b1;
      bit_cycle(w[d ? (WIDTH - 1 - i) : i], (i == 0), 1'b1, d);
    end
  endtask

  // Compare the held word against the oldest expected word.
  task automatic expect_word(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_data"}, {28'd0, Out}, {28'd0, sb[0]});
    end
  endtask

  task automatic pop_sb();
    if (sb.size() != 0) tmp = sb.pop_front();
  endtask

  initial begin
    clear     = 1'b1;
    sin       = 1'b0;
    sin_valid = 1'b0;
    sof       = 1'b0;
    dir       = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out", {28'd0, Out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;

    // LSB first, consecutive bits 1,0,1,1 -> 4'b1101
    out_ready = 1'b1;
    sb.push_back(4'b1101);
    bit_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("lsb_busy1", {31'd0, busy}, 32'd1);
    bit_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lsb_busy2", {31'd0, busy}, 32'd1);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("lsb_busy3", {31'd0, busy}, 32'd1);
    chk("lsb_novalid3", {31'd0, out_valid}, 32'd0);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    expect_word("lsb");
    chk("lsb_busy4", {31'd0, busy}, 32'd0);
    idle(1);
    pop_sb();
    chk("lsb_consumed", {31'd0, out_valid}, 32'd0);

    // MSB first with gaps; dir toggles after the start bit and must not matter
    sb.push_back(4'b1011);
    bit_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    bit_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("msb_busy_gap", {31'd0, busy}, 32'd1);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    expect_word("msb");
    idle(1);
    pop_sb();
    chk("msb_consumed", {31'd0, out_valid}, 32'd0);

    // Backpressure: A held, 5 dropped
    out_ready = 1'b0;
    sb.push_back(4'hA);
    send_word(4'hA, 1'b0, 1'b0);
    expect_word("bp_first");
    chk("bp_no_overrun", {31'd0, overrun}, 32'd0);
    send_word(4'h5, 1'b0, 1'b0);
    expect_word("bp_held");
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    idle(1);
    pop_sb();
    out_ready = 1'b0;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-frame with a word pending and overrun set
    sb.push_back(4'h3);
    send_word(4'h3, 1'b1, 1'b0);
    expect_word("prerst");
    bit_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("prerst_busy", {31'd0, busy}, 32'd1);
    sin_valid = 1'b0;
    clear     = 1'b1;
    #1;
    chk("arst_out", {28'd0, Out}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    sb.delete();
    idle(2);
    clear = 1'b0;

    // Same-edge replace: hold 3, complete C on the edge that consumes 3
    sb.push_back(4'h3);
    send_word(4'h3, 1'b0, 1'b0);
    expect_word("rep_hold");
    sb.push_back(4'hC);
    send_word(4'hC, 1'b0, 1'b1);
    pop_sb();
    expect_word("rep_new");
    chk("rep_overrun", {31'd0, overrun}, 32'd0);
    idle(1);
    pop_sb();
    chk("rep_consumed", {31'd0, out_valid}, 32'd0);

    // Stray bits while idle, then a restart after two bits
    out_ready = 1'b1;
    repeat (3) bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_valid", {31'd0, out_valid}, 32'd0);
    bit_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rs_busy", {31'd0, busy}, 32'd1);
    sb.push_back(4'b0110);
    bit_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rs_novalid", {31'd0, out_valid}, 32'd0);
    bit_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    expect_word("rs");
    idle(1);
    pop_sb();
    idle(3);
    chk("rs_single", {31'd0, out_valid}, 32'd0);
    chk("rs_sb_empty", sb.size(), 32'd0);
    chk("rs_overrun", {31'd0, overrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ser_word_rx.md
# ser_word_rx

Serial-to-parallel word receiver: the receiving end of the serial stream produced by the team's universal shift register when it shifts a loaded word out through its serial end. It collects WIDTH bits from a strobed one-bit input and reassembles them into a parallel word in either bit order. It presents each completed word on a valid/ready output port with one word of holding buffer and a sticky overrun flag. It sits between a serial link and any parallel consumer that stalls.

## Interface

Parameters:
- WIDTH, 4, word length in bits; legal range is 2 to 32.

Ports:
- clk  in  1  Single clock. All state updates on the rising edge.
- clear  in  1  Reset, asynchronous, active-high. Clears all state immediately.
- sin  in  1  Serial data bit. Sampled only when sin_valid=1.
- sin_valid  in  1  Bit strobe. Exactly one bit is consumed per clk edge where sin_valid=1.
- sof  in  1  Start of frame. Qualified by sin_valid. Marks the current bit as bit 1 of a new word.
- dir  in  1  Bit order. 0 means LSB first (right-shift stream). 1 means MSB first (left-shift stream). Sampled only on a qualified sof.
- Out  out  WIDTH  Received word. Valid only while out_valid=1.
- out_valid  out  1  A word is held on Out.
- out_ready  in  1  The consumer accepts Out on an edge where out_valid=1 and out_ready=1.
- busy  out  1  A frame is partially received (state SHIFT).
- overrun  out  1  Sticky flag: a completed word was dropped. Cleared only by clear.

## Operation

- Internal state:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt, 0..WIDTH-1
  - latched order bit dir_q
  - FSM with states IDLE and SHIFT
  - output holding register Out with flag out_valid
- "Bit event" means sin_valid=1 at a clk edge.
- Shift rule:
  - dir_q=0: sr <= {sin, sr[WIDTH-1:1]}. The first bit received ends in Out[0].
  - dir_q=1: sr <= {sr[WIDTH-2:0], sin}. The first bit received ends in Out[WIDTH-1].
- IDLE state:
  - A bit event with sof=0 is ignored.
  - A bit event with sof=1 latches dir_q<=dir, shifts in sin, sets cnt<=1, and moves to SHIFT.
- SHIFT state:
  - A bit event with sof=1 restarts the frame. The partial word is discarded without a flag, dir is re-latched, this bit becomes bit 1, and cnt<=1.
  - A bit event with sof=0 shifts in sin and increments cnt.
  - When the bit event delivers the WIDTH-th bit (cnt=WIDTH-1 before the edge), the word completes. The FSM returns to IDLE and cnt<=0.
- Word completion (the assembled word includes the bit arriving on this edge):
  - out_valid=0, or out_valid=1 with out_ready=1 on the same edge: Out <= word and out_valid <= 1. The old word is consumed and replaced.
  - out_valid=1 with out_ready=0: the new word is dropped, overrun <= 1, and Out is unchanged.
- Handshake:
  - An edge with out_valid=1, out_ready=1 and no completion clears out_valid on that edge.
  - Out is stable while out_valid=1 and out_ready=0.
- busy = (state==SHIFT).
- With no bit events, cnt, sr and the FSM hold their values indefinitely. There is no timeout.

## Timing

- Reset values: Out=0, out_valid=0, busy=0, overrun=0. Internal reset values: sr=0, cnt=0, dir_q=0, state=IDLE.
- Reset timing:
  - Outputs reach their reset values asynchronously on clear rising, with no clk edge needed.
  - The block stays in reset while clear=1.
  - Asserting clear mid-frame or with a word pending loses the frame or word.
- Latency: out_valid and the new Out are visible immediately after the edge carrying the WIDTH-th bit.
- Minimum frame time is WIDTH cycles (sin_valid held high).
- Throughput:
  - Back-to-back frames (sof on the cycle after the last bit) are accepted.
  - With out_ready tied high, no overrun occurs.
- Gaps in sin_valid of any length between bits are legal and do not affect the result.
- Simultaneous events:
  - Completion and consumption on the same edge: out_valid stays 1 with the new word and no overrun.
  - A sof bit on the completion edge cannot occur; the WIDTH-th bit with sof=1 is treated as a restart.

## Test plan

- Reset: assert clear mid-frame after 2 bits, with out_valid=1 and overrun=1 -> all outputs 0 immediately, with no clk edge. After release, a fresh frame decodes correctly.
- LSB first: WIDTH=4, dir=0, bits 1,0,1,1 on consecutive cycles, sof on the first bit, out_ready=1 -> Out=4'b1101 and out_valid=1 after the 4th edge. busy=1 after edges 1-3.
- MSB first with gaps: dir=1, bits 1,0,1,1 with 0-3 idle cycles between strobes -> Out=4'b1011. Changing dir mid-frame has no effect.
- Backpressure:
  - With out_ready=0, send two frames 4'hA then 4'h5 -> Out stays 4'hA and overrun=1.
  - Then pulse out_ready -> out_valid=0 and overrun remains 1.
- Same-edge replace: hold word 4'h3, then complete 4'hC on the edge where out_ready=1 -> Out=4'hC, out_valid stays 1, overrun=0.
- Restart and stray bits:
  - Bits with sof=0 while IDLE are ignored.
  - sof after 2 bits, then bits 0,1,1,0 with dir=0 -> Out=4'b0110. Only that word is produced.
